// File: rtl/integer_multiplier_result_serializer.sv
// integer_multiplier_result_serializer
//
// Sits downstream of integer_multiplier. Each 128-bit product, together with
// its sign flag, is accepted over the multiplier's valid/ack handshake and
// queued in a small FIFO. Every queued product is then sent to the 64-bit
// integer writeback bus as two beats, low half first, over a valid/ready
// handshake. Multiplier completion and writeback arbitration are therefore
// decoupled.
//
// Ports
//   clk_in, reset_in    clock; asynchronous active-high reset
//   product_valid_in    multiplier offers a product
//   product_sign_in     sign flag that travels with the product
//   product_in          product data
//   issue_ack_out       one-cycle acknowledge of a captured product
//   result_valid_out    a beat is available (FIFO not empty)
//   result_ready_in     writeback accepts the current beat
//   result_half_out     0 = low half on result_out, 1 = high half
//   result_sign_out     stored sign flag of the head entry
//   result_out          beat data
//   occupancy_out       number of products held
//   full_out, empty_out occupancy == FIFO_DEPTH / occupancy == 0
//
// Beat sequencer states
//   state     | meaning
//   BEAT_LOW  | head entry shows its low half; a transfer moves to BEAT_HIGH
//   BEAT_HIGH | head entry shows its high half; a transfer pops the entry
module integer_multiplier_result_serializer #(
  parameter int OPERAND_WIDTH_IN_BITS = 64,
  parameter int PRODUCT_WIDTH_IN_BITS = 128,
  parameter int FIFO_DEPTH            = 4,
  parameter int COUNT_WIDTH           = 3
) (
  input  logic                             clk_in,
  input  logic                             reset_in,
  input  logic                             product_valid_in,
  input  logic                             product_sign_in,
  input  logic [PRODUCT_WIDTH_IN_BITS-1:0] product_in,
  output logic                             issue_ack_out,
  output logic                             result_valid_out,
  input  logic                             result_ready_in,
  output logic                             result_half_out,
  output logic                             result_sign_out,
  output logic [OPERAND_WIDTH_IN_BITS-1:0] result_out,
  output logic [COUNT_WIDTH-1:0]           occupancy_out,
  output logic                             full_out,
  output logic                             empty_out
);

  localparam int PTR_WIDTH   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_WIDTH = PRODUCT_WIDTH_IN_BITS + 1;
  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(FIFO_DEPTH);

  typedef enum logic {
    BEAT_LOW  = 1'b0,
    BEAT_HIGH = 1'b1
  } beat_state_t;

  beat_state_t beat_q, beat_d;

  // Entry layout: {sign, product}
  logic [ENTRY_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COUNT_WIDTH-1:0] occ_q, occ_d;
  logic                   ack_q, ack_d;

  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   beat_xfer;
  logic                   pop;
  logic [ENTRY_WIDTH-1:0] head;

  assign full  = (occ_q == FULL_COUNT);
  assign empty = (occ_q == '0);

  // The multiplier may keep showing the product it was just acked for during
  // the ack cycle, so captures are blocked while ack is high. Fullness is
  // judged on the registered occupancy only; a same-cycle pop does not make
  // room for a push.
  assign push      = product_valid_in & ~full & ~ack_q;
  assign beat_xfer = ~empty & result_ready_in;
  assign pop       = beat_xfer & (beat_q == BEAT_HIGH);

  always_comb begin
    beat_d   = beat_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ack_d    = push;

    if (beat_xfer) begin
      case (beat_q)
        BEAT_LOW:  beat_d = BEAT_HIGH;
        BEAT_HIGH: beat_d = BEAT_LOW;
        default:   beat_d = BEAT_LOW;
      endcase
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + COUNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - COUNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      beat_q   <= BEAT_LOW;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ack_q    <= ack_d;
    end
  end

  // Storage carries no reset; contents are only observed while occupied.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {product_sign_in, product_in};
    end
  end

  assign head = mem_q[rd_ptr_q];

  assign issue_ack_out    = ack_q;
  assign result_valid_out = ~empty;
  assign result_half_out  = (beat_q == BEAT_HIGH);
  assign result_sign_out  = head[ENTRY_WIDTH-1];
  assign result_out       = (beat_q == BEAT_HIGH)
                            ? head[PRODUCT_WIDTH_IN_BITS-1:OPERAND_WIDTH_IN_BITS]
                            : head[OPERAND_WIDTH_IN_BITS-1:0];
  assign occupancy_out    = occ_q;
  assign full_out         = full;
  assign empty_out        = empty;

endmodule

// File: tb/tb_integer_multiplier_result_serializer.sv
// Bench for integer_multiplier_result_serializer: directed vectors, inputs
// driven and outputs sampled on the falling clock edge.
module tb_integer_multiplier_result_serializer;

  localparam int OW    = 64;
  localparam int PW    = 128;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk_in = 1'b0;
  logic          reset_in;
  logic          product_valid_in;
  logic          product_sign_in;
  logic [PW-1:0] product_in;
  logic          issue_ack_out;
  logic          result_valid_out;
  logic          result_ready_in;
  logic          result_half_out;
  logic          result_sign_out;
  logic [OW-1:0] result_out;
  logic [CW-1:0] occupancy_out;
  logic          full_out;
  logic          empty_out;

  int n_cmp = 0;
  int n_err = 0;

  integer_multiplier_result_serializer #(
    .OPERAND_WIDTH_IN_BITS(OW),
    .PRODUCT_WIDTH_IN_BITS(PW),
    .FIFO_DEPTH(DEPTH),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .product_valid_in(product_valid_in),
    .product_sign_in(product_sign_in),
    .product_in(product_in),
    .issue_ack_out(issue_ack_out),
    .result_valid_out(result_valid_out),
    .result_ready_in(result_ready_in),
    .result_half_out(result_half_out),
    .result_sign_out(result_sign_out),
    .result_out(result_out),
    .occupancy_out(occupancy_out),
    .full_out(full_out),
    .empty_out(empty_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [PW:0] obs, input logic [PW:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_in);
  endtask

  // Stream vector i: {sign, product}; product is a real 64x64 multiply.
  function automatic logic [PW:0] vec(input int i);
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] p;
    a = 64'h9E37_79B9_7F4A_7C15 * 64'(i + 1);
    b = {32'(i * 7 + 3), 32'hDEAD_0000 | 32'(i)};
    if (i[1]) b = ~b;
    p = {64'd0, a} * {64'd0, b};
    return {i[0] ^ a[63], p};
  endfunction

  task automatic take_beat(input string tag, input logic [PW:0] e, input logic hi);
    result_ready_in = 1'b1;
    check_eq({tag, "_valid"}, result_valid_out, 1);
    check_eq({tag, "_half"}, result_half_out, hi);
    check_eq({tag, "_data"}, result_out, hi ? e[PW-1:OW] : e[OW-1:0]);
    check_eq({tag, "_sign"}, result_sign_out, e[PW]);
    step();
  endtask

  task automatic push_one(input logic [PW:0] e);
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = e;
    step();
    check_eq("push_ack", issue_ack_out, 1);
    product_valid_in = 1'b0;
    step();
    check_eq("push_ack_clear", issue_ack_out, 0);
  endtask

  task automatic check_empty(input string tag);
    check_eq({tag, "_empty"}, empty_out, 1);
    check_eq({tag, "_valid"}, result_valid_out, 0);
    check_eq({tag, "_occ"}, occupancy_out, 0);
  endtask

  // Multiplier model keeps the acked product visible for the ack cycle and
  // moves to the next one a cycle later; writeback stalls for 'stall' cycles.
  task automatic run_traffic(input string tag, input int n, input int base, input int stall);
    int   sent = 0;
    int   acks = 0;
    int   beats = 0;
    int   cyc = 0;
    logic ack_seen = 1'b0;
    logic [PW:0] e;
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = vec(base);
    result_ready_in = (stall == 0);
    while (beats < 2 * n && cyc < 2000) begin
      if (stall > 0 && cyc == stall) begin
        check_eq({tag, "_full"}, full_out, 1);
        check_eq({tag, "_occ_full"}, occupancy_out, DEPTH);
        check_eq({tag, "_acks_while_full"}, acks, DEPTH);
        check_eq({tag, "_no_ack_full"}, issue_ack_out, 0);
        result_ready_in = 1'b1;
      end
      if (result_valid_out && result_ready_in) begin
        e = vec(base + beats / 2);
        check_eq({tag, "_half"}, result_half_out, beats % 2);
        check_eq({tag, "_data"}, result_out, (beats % 2) ? e[PW-1:OW] : e[OW-1:0]);
        check_eq({tag, "_sign"}, result_sign_out, e[PW]);
        beats++;
      end
      if (ack_seen) begin
        sent++;
        if (sent < n) {product_sign_in, product_in} = vec(base + sent);
        else product_valid_in = 1'b0;
      end
      ack_seen = issue_ack_out;
      if (issue_ack_out) acks++;
      step();
      cyc++;
    end
    product_valid_in = 1'b0;
    check_eq({tag, "_beats"}, beats, 2 * n);
    check_eq({tag, "_acks"}, acks, n);
    check_empty(tag);
  endtask

  initial begin
    logic [PW:0] p_single;
    logic [PW:0] pa;
    logic [PW:0] pb;
    logic [PW:0] pc;

    reset_in         = 1'b1;
    product_valid_in = 1'b0;
    product_sign_in  = 1'b0;
    product_in       = '0;
    result_ready_in  = 1'b0;
    step();
    step();
    check_eq("rst_ack", issue_ack_out, 0);
    check_eq("rst_valid", result_valid_out, 0);
    check_eq("rst_half", result_half_out, 0);
    check_eq("rst_occ", occupancy_out, 0);
    check_eq("rst_empty", empty_out, 1);
    check_eq("rst_full", full_out, 0);
    reset_in = 1'b0;
    step();

    // Single product
    p_single = {1'b1, 128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFFE};
    result_ready_in  = 1'b1;
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = p_single;
    step();
    check_eq("single_ack", issue_ack_out, 1);
    check_eq("single_occ", occupancy_out, 1);
    product_valid_in = 1'b0;
    check_eq("single_lo_value", result_out, 64'hFFFF_FFFF_FFFF_FFFE);
    take_beat("single_lo", p_single, 1'b0);
    check_eq("single_ack_clear", issue_ack_out, 0);
    check_eq("single_hi_value", result_out, 64'h0000_0000_0000_0002);
    take_beat("single_hi", p_single, 1'b1);
    check_empty("single_end");

    // Back-to-back, 64 products
    run_traffic("b2b", 64, 0, 0);

    // Full backpressure, 6 products into a depth-4 FIFO
    run_traffic("full", 6, 100, 30);

    // Mid-pair stall with a new entry arriving during the stall
    pa = vec(200);
    pb = vec(201);
    result_ready_in = 1'b0;
    push_one(pa);
    take_beat("stall_lo", pa, 1'b0);
    result_ready_in  = 1'b0;
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = pb;
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_hold_valid", result_valid_out, 1);
      check_eq("stall_hold_half", result_half_out, 1);
      check_eq("stall_hold_data", result_out, pa[PW-1:OW]);
      if (issue_ack_out) product_valid_in = 1'b0;
      step();
    end
    check_eq("stall_occ", occupancy_out, 2);
    take_beat("stall_hi", pa, 1'b1);
    take_beat("stall_new_lo", pb, 1'b0);
    take_beat("stall_new_hi", pb, 1'b1);
    check_empty("stall_end");

    // Simultaneous push and pop at occupancy 2
    pa = vec(300);
    pb = vec(301);
    pc = vec(302);
    result_ready_in = 1'b0;
    push_one(pa);
    push_one(pb);
    check_eq("simul_occ_before", occupancy_out, 2);
    take_beat("simul_a_lo", pa, 1'b0);
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = pc;
    take_beat("simul_a_hi", pa, 1'b1);
    product_valid_in = 1'b0;
    check_eq("simul_occ_after", occupancy_out, 2);
    check_eq("simul_ack", issue_ack_out, 1);
    take_beat("simul_b_lo", pb, 1'b0);
    take_beat("simul_b_hi", pb, 1'b1);
    take_beat("simul_c_lo", pc, 1'b0);
    take_beat("simul_c_hi", pc, 1'b1);
    check_empty("simul_end");

    // Asynchronous reset with 3 entries and the high half pending
    result_ready_in = 1'b0;
    push_one(vec(400));
    push_one(vec(401));
    push_one(vec(402));
    result_ready_in = 1'b1;
    step();
    result_ready_in = 1'b0;
    check_eq("mid_rst_pre_half", result_half_out, 1);
    check_eq("mid_rst_pre_occ", occupancy_out, 3);
    #2 reset_in = 1'b1;
    #1;
    check_eq("mid_rst_ack", issue_ack_out, 0);
    check_eq("mid_rst_valid", result_valid_out, 0);
    check_eq("mid_rst_half", result_half_out, 0);
    check_eq("mid_rst_occ", occupancy_out, 0);
    check_eq("mid_rst_empty", empty_out, 1);
    check_eq("mid_rst_full", full_out, 0);
    step();
    reset_in = 1'b0;
    step();
    pa = vec(500);
    result_ready_in = 1'b1;
    product_valid_in = 1'b1;
    {product_sign_in, product_in} = pa;
    step();
    product_valid_in = 1'b0;
    check_eq("post_rst_ack", issue_ack_out, 1);
    take_beat("post_rst_lo", pa, 1'b0);
    take_beat("post_rst_hi", pa, 1'b1);
    check_empty("post_rst_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
